// File: rtl/mux_four_arbiter_pkg.sv
// rtl/mux_four_arbiter_pkg.sv - shared constants, state type and helpers for the 4-way mux arbiter
package mux_four_arbiter_pkg;

    localparam int ARB_N = 4;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    // Hold counter width: max(1, clog2(max_hold)).
    function automatic int hold_width(input int max_hold);
        return (max_hold > 2) ? $clog2(max_hold) : 1;
    endfunction

    function automatic logic [ARB_N-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_four_arbiter_if.sv
// rtl/mux_four_arbiter_if.sv - request/grant/select bundle between requesters and the arbiter
interface mux_four_arbiter_if;
    import mux_four_arbiter_pkg::*;

    logic [ARB_N-1:0] req;
    logic [ARB_N-1:0] grant;
    logic [1:0]       select;
    logic             busy;

    modport master (
        output req,
        input  grant,
        input  select,
        input  busy
    );

    modport slave (
        input  req,
        output grant,
        output select,
        output busy
    );

endinterface

// File: rtl/mux_four_arbiter_rr_pick.sv
// rtl/mux_four_arbiter_rr_pick.sv - combinational round-robin picker: first set req bit from ptr upward, mod 4
module rr_pick_four
    import mux_four_arbiter_pkg::*;
(
    input  logic [ARB_N-1:0] req,
    input  logic [1:0]       ptr,
    output logic [1:0]       idx,
    output logic             found
);

    logic [1:0] pos;

    // Scan from the farthest offset down so the nearest hit to ptr wins last.
    always_comb begin
        idx   = 2'd0;
        found = 1'b0;
        pos   = 2'd0;
        for (int k = ARB_N - 1; k >= 0; k--) begin
            pos = ptr + 2'(k);
            if (req[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_four_arbiter.sv
// rtl/mux_four_arbiter.sv - round-robin arbiter driving the select of a shared 4:1 mux with a hold limit
module mux_four_arbiter
    import mux_four_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               reset,
    mux_four_arbiter_if.slave  bus
);

    localparam int             HW        = hold_width(MAX_HOLD);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0]  HOLD_ONE  = HW'(1);

    arb_state_t       state, state_n;
    logic [1:0]       owner, owner_n;
    logic [1:0]       ptr, ptr_n;
    logic [HW-1:0]    hold_cnt, hold_n;

    logic [ARB_N-1:0] grant_q;
    logic [1:0]       select_q;
    logic             busy_q;

    logic [1:0]       pick_ptr;
    logic [1:0]       pick_idx;
    logic             pick_found;
    logic             others;
    logic             release_now;

    // While owned, the only pick that matters is the re-pick on release, which scans from owner+1.
    assign pick_ptr    = (state == ARB_OWNED) ? (owner + 2'd1) : ptr;
    assign others      = |(bus.req & ~onehot4(owner));
    assign release_now = !bus.req[owner] || ((hold_cnt == HOLD_LAST) && others);

    rr_pick_four u_pick (
        .req   (bus.req),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_n = ARB_OWNED;
                    owner_n = pick_idx;
                    hold_n  = '0;
                end
            end
            ARB_OWNED: begin
                if (release_now) begin
                    ptr_n = owner + 2'd1;
                    if (pick_found) begin
                        owner_n = pick_idx;
                        hold_n  = '0;
                    end else begin
                        state_n = ARB_IDLE;
                    end
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_n = hold_cnt + HOLD_ONE;
                end
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so grant and select switch on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB_IDLE;
            owner    <= 2'd0;
            ptr      <= 2'd0;
            hold_cnt <= '0;
            grant_q  <= '0;
            select_q <= 2'd0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            grant_q  <= (state_n == ARB_OWNED) ? onehot4(owner_n) : '0;
            select_q <= owner_n;
            busy_q   <= (state_n == ARB_OWNED);
        end
    end

    assign bus.grant  = grant_q;
    assign bus.select = select_q;
    assign bus.busy   = busy_q;

endmodule
